// File: rtl/mult_pkg.sv
// Shared sizing helpers for the pipelined multiplier: product width, carry-save
// tree depth, per-rank level split and parallel-prefix adder dimensions.
package mult_pkg;

    localparam int PREFIX_MAX_WIDTH = 64;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Depth of a 3:2 carry-save tree that reduces `rows` rows down to two.
    function automatic int tree_levels(input int rows);
        int n;
        int lv;
        n  = rows;
        lv = 0;
        while (n > 2) begin
            n  = 2 * (n / 3) + (n % 3);
            lv = lv + 1;
        end
        return lv;
    endfunction

    // Earlier ranks take the remainder so the split differs by at most one level.
    function automatic int levels_for_rank(input int rows, input int stages, input int rank);
        int total;
        total = tree_levels(rows);
        return (total / stages) + ((rank < (total % stages)) ? 1 : 0);
    endfunction

    function automatic int prefix_levels(input int n);
        int lv;
        lv = 0;
        while ((32'd1 << lv) < n) begin
            lv = lv + 1;
        end
        return lv;
    endfunction

    function automatic int prefix_black_cells(input int n);
        int cells;
        cells = 0;
        for (int l = 0; l < prefix_levels(n); l++) begin
            cells = cells + (n - int'(32'd1 << l));
        end
        return cells;
    endfunction

endpackage

// File: rtl/mult_prefix_add.sv
// Kogge-Stone style parallel-prefix adder resolving the final two carry-save rows.
// The carry out of the top bit is not produced; sums wrap modulo 2**N.
module mult_prefix_add
    import mult_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s
);

    // Carries are only needed into bits 1..N-1, so the prefix spans N-1 bits.
    localparam int M  = N - 1;
    localparam int LV = prefix_levels(M);

    logic [N-1:0] p0_s;
    logic [M-1:0] g_s [LV+1];
    logic [M-1:0] p_s [LV+1];

    assign p0_s = a ^ b;

    // Generate/propagate prefix network; low bits pass through as grey cells.
    always_comb begin
        g_s[0] = a[M-1:0] & b[M-1:0];
        p_s[0] = p0_s[M-1:0];
        for (int l = 0; l < LV; l++) begin
            for (int i = 0; i < M; i++) begin
                if (i >= int'(32'd1 << l)) begin
                    g_s[l+1][i] = g_s[l][i] | (p_s[l][i] & g_s[l][i - int'(32'd1 << l)]);
                    p_s[l+1][i] = p_s[l][i] & p_s[l][i - int'(32'd1 << l)];
                end else begin
                    g_s[l+1][i] = g_s[l][i];
                    p_s[l+1][i] = p_s[l][i];
                end
            end
        end
    end

    assign s = p0_s ^ {g_s[LV], 1'b0};

endmodule

// File: rtl/mult_pipe.sv
// Pipelined WIDTH x WIDTH multiplier with valid/ready handshake and carry-save tree.
// Define MULT_SIGNED_EN to add the tc port (Baugh-Wooley two's complement mode).
module mult_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      x,
    input  logic [WIDTH-1:0]      y,
`ifdef MULT_SIGNED_EN
    input  logic                  tc,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    o
);

    localparam int PW = prod_width(WIDTH);

    typedef logic [WIDTH-1:0][PW-1:0] rows_t;

    logic              adv_s;
    logic              tc_s;
    rows_t             pp_s;
    rows_t             next_s [STAGES];
    rows_t             data_r [STAGES];
    logic [STAGES-1:0] valid_r;

`ifdef MULT_SIGNED_EN
    assign tc_s = tc;
`else
    assign tc_s = 1'b0;
`endif

    // One 3:2 level over every row slot; empty slots are zero and stay zero.
    function automatic rows_t csa_level(input rows_t r);
        rows_t res;
        res = '0;
        for (int g = 0; g < WIDTH / 3; g++) begin
            res[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
            res[2*g+1] = {((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) |
                           (r[3*g+1] & r[3*g+2])), 1'b0} >> 1;
            res[2*g+1] = {res[2*g+1][PW-2:0], 1'b0};
        end
        for (int j = 0; j < WIDTH % 3; j++) begin
            res[2*(WIDTH/3)+j] = r[3*(WIDTH/3)+j];
        end
        return res;
    endfunction

    function automatic rows_t reduce_rows(input rows_t r, input int n);
        rows_t t;
        t = r;
        for (int l = 0; l < n; l++) begin
            t = csa_level(t);
        end
        return t;
    endfunction

    // Partial-product matrix; in signed mode the sign-row/column cross terms are
    // inverted and the constant correction bits ride in the free top of row 0.
    always_comb begin
        pp_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp_s[i][i+j] = (x[j] & y[i]) ^
                               (tc_s & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        pp_s[0][WIDTH]  = tc_s;
        pp_s[0][PW-1]   = tc_s;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_rank
        localparam int LVK = levels_for_rank(WIDTH, STAGES, k);
        if (k == 0) begin : g_first
            assign next_s[k] = reduce_rows(pp_s, LVK);
        end else begin : g_next
            assign next_s[k] = reduce_rows(data_r[k-1], LVK);
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign adv_s     = !valid_r[STAGES-1] || out_ready;
    assign in_ready  = adv_s;

    // Rank registers: all ranks shift together on adv, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_r[k] <= '0;
            end
        end else if (adv_s) begin
            valid_r[0] <= in_valid;
            data_r[0]  <= next_s[0];
            for (int k = 1; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
                data_r[k]  <= next_s[k];
            end
        end
    end

    mult_prefix_add #(
        .N (PW)
    ) u_add (
        .a (data_r[STAGES-1][0]),
        .b (data_r[STAGES-1][1]),
        .s (o)
    );

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed table, back-pressure, streaming,
// random handshake traffic and asynchronous reset while products are in flight.
module tb_mult_pipe;

    localparam int W = 8;
    localparam int S = 2;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           tcb;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] o;

    int n_chk;
    int n_fail;
    int dut_out;
    int cnt;

    logic           mv [S];
    logic [2*W-1:0] mp [S];

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           t;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs [$];

    mult_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
`ifdef MULT_SIGNED_EN
        .tc        (tcb),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic t);
        longint sa;
        longint sb;
        longint p;
        sa = longint'(a);
        sb = longint'(b);
        if (t && a[W-1]) sa = sa - (64'sd1 <<< W);
        if (t && b[W-1]) sb = sb - (64'sd1 <<< W);
        p = sa * sb;
        return p[2*W-1:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < S; k++) begin
            mv[k] = 1'b0;
            mp[k] = '0;
        end
    endtask

    // One clock: compare outputs at negedge, then advance the reference model.
    task automatic tick();
        logic adv;
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, mv[S-1]});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!mv[S-1] || out_ready)});
        if (mv[S-1]) chk("o", {16'd0, o}, {16'd0, mp[S-1]});
        if (out_valid && out_ready) dut_out++;
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
        end else begin
            adv = !mv[S-1] || out_ready;
            if (adv) begin
                for (int k = S - 1; k > 0; k--) begin
                    mv[k] = mv[k-1];
                    mp[k] = mp[k-1];
                end
                mv[0] = in_valid;
                mp[0] = ref_prod(x, y, tcb);
            end
        end
        #1;
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        dut_out  = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x        = '0;
        y        = '0;
        tcb      = 1'b0;
        clear_model();

        vecs.push_back('{a: 8'hFF, b: 8'hFF, t: 1'b0, exp: 16'hFE01});
        vecs.push_back('{a: 8'h00, b: 8'hA5, t: 1'b0, exp: 16'h0000});
        vecs.push_back('{a: 8'h01, b: 8'hFF, t: 1'b0, exp: 16'h00FF});
        vecs.push_back('{a: 8'h0D, b: 8'h0B, t: 1'b0, exp: 16'h008F});
        vecs.push_back('{a: 8'h80, b: 8'h80, t: 1'b0, exp: 16'h4000});
        vecs.push_back('{a: 8'h7F, b: 8'h02, t: 1'b0, exp: 16'h00FE});
        vecs.push_back('{a: 8'h80, b: 8'h7F, t: 1'b0, exp: 16'h3F80});
`ifdef MULT_SIGNED_EN
        vecs.push_back('{a: 8'h80, b: 8'h7F, t: 1'b1, exp: 16'hC080});
        vecs.push_back('{a: 8'hFF, b: 8'hFF, t: 1'b1, exp: 16'h0001});
        vecs.push_back('{a: 8'hFF, b: 8'h01, t: 1'b1, exp: 16'hFFFF});
        vecs.push_back('{a: 8'h80, b: 8'h80, t: 1'b1, exp: 16'h4000});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_o", {16'd0, o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_o", {16'd0, o}, 32'd0);

        foreach (vecs[i]) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            x   = vecs[i].a;
            y   = vecs[i].b;
            tcb = vecs[i].t;
            tick();
            in_valid = 1'b0;
            repeat (S - 1) tick();
            chk("tbl_valid", {31'd0, out_valid}, 32'd1);
            chk("tbl_o", {16'd0, o}, {16'd0, vecs[i].exp});
            tick();
        end
        tcb = 1'b0;

        out_ready = 1'b0;
        in_valid  = 1'b1;
        x = 8'd13;
        y = 8'd11;
        tick();
        in_valid = 1'b0;
        repeat (S - 1) tick();
        in_valid = 1'b1;
        x = 8'd3;
        y = 8'd5;
        for (int c = 0; c < 5; c++) begin
            chk("bp_o", {16'd0, o}, 32'd143);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        cnt = dut_out;
        tick();
        in_valid = 1'b0;
        chk("bp_single_xfer", dut_out - cnt, 32'd1);
        chk("bp_after_valid", {31'd0, out_valid}, 32'd0);
        repeat (S + 1) tick();

        cnt = dut_out;
        for (int c = 0; c < 256; c++) begin
            in_valid = 1'b1;
            x = W'($urandom);
            y = W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        repeat (S) tick();
        chk("stream_count", dut_out - cnt, 32'd256);

        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            x = W'($urandom);
            y = W'($urandom);
`ifdef MULT_SIGNED_EN
            tcb = 1'($urandom_range(0, 1));
`endif
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (S + 1) tick();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        x = 8'h21;
        y = 8'h33;
        tick();
        x = 8'h44;
        y = 8'h55;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_o", {16'd0, o}, 32'd0);
        clear_model();
        cnt = dut_out;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("midrst_no_xfer", dut_out - cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
